// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache. It sits between the CPU
// MEM stage and a slow main memory that transfers whole 16-byte lines.
//
// Address split (NUM_LINES lines, IDX = log2(NUM_LINES)):
//   tag = addr[31:4+IDX], index = addr[4+IDX-1:4], word = addr[3:2]
//
// Ports:
//   clk_i       clock, rising edge
//   start_i     asynchronous active-low reset
//   addr_i      CPU byte address (bits [1:0] ignored)
//   data_i      CPU store data
//   MemRead_i   CPU load request
//   MemWrite_i  CPU store request (wins over MemRead_i)
//   data_o      load data, combinational on a hit, 0 otherwise
//   stall_o     freeze the pipeline while a miss is being serviced
//   mem_req_o   main-memory request
//   mem_we_o    1 = line write-back, 0 = line fetch
//   mem_addr_o  line address (bits [3:0] = 0)
//   mem_data_o  write-back line, word0 in [31:0]
//   mem_data_i  fetched line, word0 in [31:0]
//   mem_ack_i   one-cycle completion pulse for the current request
//   hit_cnt_o   accesses that hit on first lookup (wraps)
//   miss_cnt_o  accesses that missed (wraps)
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk_i,
    input  logic         start_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  data_i,
    input  logic         MemRead_i,
    input  logic         MemWrite_i,
    output logic [31:0]  data_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_data_o,
    input  logic [127:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic                 replay_q;   // next IDLE hit is the re-execution of a miss

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    // Address decode
    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word_sel;
    logic [6:0]       word_lsb;
    logic             unused_addr_bits;

    assign idx              = addr_i[4+IDX-1:4];
    assign tag              = addr_i[31:4+IDX];
    assign word_sel         = addr_i[3:2];
    assign word_lsb         = {word_sel, 5'b0};
    assign unused_addr_bits = ^addr_i[1:0];

    // Lookup
    logic             access;
    logic             hit;
    logic             in_idle;
    logic [127:0]     cur_line;
    logic [TAG_W-1:0] cur_tag;

    assign cur_line = data_mem[idx];
    assign cur_tag  = tag_mem[idx];
    assign access   = MemRead_i | MemWrite_i;
    assign hit      = access & valid_q[idx] & (cur_tag == tag);
    assign in_idle  = (state == IDLE);

    // Stall is gated by start_i so the pipeline is released the instant reset
    // is applied, even if the CPU is still presenting a missing access.
    assign stall_o = start_i & (~in_idle | (access & ~hit));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        data_o = '0;
        if (in_idle && hit && !MemWrite_i) begin
            data_o = cur_line[word_lsb +: 32];
        end
    end

    // Control FSM with registered memory-side outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state      <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            replay_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    replay_q <= 1'b0;
                    if (hit) begin
                        if (!replay_q) begin
                            hit_cnt_o <= hit_cnt_o + 32'd1;
                        end
                        if (MemWrite_i) begin
                            dirty_q[idx] <= 1'b1;
                        end
                    end else if (access) begin
                        miss_cnt_o <= miss_cnt_o + 32'd1;
                        mem_req_o  <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state      <= WRITEBACK;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= {cur_tag, idx, 4'b0};
                            mem_data_o <= cur_line;
                        end else begin
                            state      <= ALLOCATE;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {addr_i[31:4], 4'b0};
                        end
                    end
                end

                WRITEBACK: begin
                    // Request stays up; it simply turns into the line fetch.
                    if (mem_ack_i) begin
                        state      <= ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {addr_i[31:4], 4'b0};
                    end
                end

                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        mem_req_o    <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        replay_q     <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

    // Line storage. A refill and a store hit can never coincide: the refill
    // happens in ALLOCATE, the store merge in the following IDLE cycle.
    // NOTE: tag and data arrays are not reset; valid_q qualifies every lookup.
    always_ff @(posedge clk_i) begin
        if (start_i && state == ALLOCATE && mem_ack_i) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= tag;
        end else if (start_i && in_idle && hit && MemWrite_i) begin
            data_mem[idx][word_lsb +: 32] <= data_i;
        end
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU MEM stage (Data_Memory-style word port: addr, write data, MemRead, MemWrite) and a slow line-wide main memory with a req/ack handshake.
- Asserts stall_o so the pipeline freezes until a missed access completes.
- Provides hit and miss performance counters.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2. IDX = log2(NUM_LINES).
- Line size is fixed at 16 bytes (4 words). Offset is addr[3:0]; word select is addr[3:2]; index is addr[4+IDX-1:4]; tag is addr[31:4+IDX].

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- start_i  in  1  reset; asynchronous, active-low.
- addr_i  in  32  CPU byte address; word aligned; bits [1:0] ignored.
- data_i  in  32  CPU write data.
- MemRead_i  in  1  CPU load request.
- MemWrite_i  in  1  CPU store request; wins if asserted together with MemRead_i.
- data_o  out  32  load data.
- stall_o  out  1  freeze the pipeline; the CPU holds addr_i, data_i and the controls stable while this is 1.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line address, bits [3:0] = 0.
- mem_data_o  out  128  write-back line; word0 in bits [31:0].
- mem_data_i  in  128  fetched line; word0 in bits [31:0].
- mem_ack_i  in  1  one-cycle completion pulse for the current request.
- hit_cnt_o  out  32  count of accesses that hit on first lookup.
- miss_cnt_o  out  32  count of accesses that missed.

Behaviour:
- Storage per line: valid bit, dirty bit, tag, 128-bit data. No data-array reset is needed.
- Reset (start_i=0, asynchronous):
  - All valid and dirty bits clear; state IDLE; replay flag clear.
  - hit_cnt_o=0, miss_cnt_o=0.
  - stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, data_o=0.
- Reset mid-operation: any outstanding memory transaction is abandoned. mem_req_o drops asynchronously, and a late mem_ack_i is ignored.
- access = MemRead_i | MemWrite_i. hit = access & valid[idx] & (tag[idx]==addr tag).
- IDLE:
  - No access: stall_o=0, data_o=0.
  - Hit, load: data_o = selected word, combinational, zero added latency; stall_o=0.
  - Hit, store: stall_o=0. At the clock edge, the selected word is replaced by data_i and dirty[idx] is set.
  - Hit, counting: if the replay flag is clear, hit_cnt++. The replay flag is cleared in every IDLE cycle.
  - Miss: stall_o=1 combinationally, miss_cnt++. Next state is WRITEBACK if valid[idx]&dirty[idx], else ALLOCATE.
- WRITEBACK:
  - stall_o=1, mem_req_o=1, mem_we_o=1.
  - mem_addr_o = {stored tag, idx, 4'b0}; mem_data_o = stored line.
  - Outputs hold until the cycle mem_ack_i=1, then the next state is ALLOCATE.
- ALLOCATE:
  - stall_o=1, mem_req_o=1, mem_we_o=0, mem_addr_o = {addr tag, idx, 4'b0}.
  - On mem_ack_i: line = mem_data_i, tag updated, valid=1, dirty=0, replay flag set, next state IDLE.
  - The access then re-executes in IDLE as a hit (stall_o=0) without incrementing hit_cnt. Store data is merged at that point.
- Miss latency: at least 2 cycles for a clean miss with ack on the first request cycle. A dirty miss adds the write-back handshake.
- mem_req_o deasserts on the cycle after ack; back-to-back requests are allowed (WRITEBACK to ALLOCATE).
- mem_ack_i while mem_req_o=0 is ignored.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- State encoding: IDLE, WRITEBACK, ALLOCATE; illegal encodings return to IDLE.

Test Plan:
- Cold read miss: reset, read 0x100; memory acks after 3 cycles with line {0xD,0xC,0xB,0xA} → mem_addr_o=0x100, mem_we_o=0, stall_o=1 until the cycle after ack, then data_o=0xA, stall_o=0; miss_cnt_o=1, hit_cnt_o=0.
- Read hit: read 0x10C → same cycle data_o=0xD, stall_o=0, no mem_req_o; hit_cnt_o=1.
- Write hit: write 0x104 with data 0x55 → no mem_req_o, stall_o=0; next read of 0x104 → data_o=0x55.
- Dirty conflict miss: read 0x204 (index 0, new tag) → WRITEBACK with mem_addr_o=0x100, mem_we_o=1, mem_data_o={0xD,0xC,0x55,0xA}; after ack, ALLOCATE with mem_addr_o=0x200, mem_we_o=0; miss_cnt_o=2.
- Store miss allocate: write 0x300 with data 0x77 to a clean line → fetch 0x300; after completion, read 0x300 → 0x77, and a later eviction writes back 0x77 in word0.
- Reset during ALLOCATE wait: drive start_i=0 → mem_req_o=0 and stall_o=0 immediately, counters 0; after release, read 0x100 misses again; a stray mem_ack_i in IDLE causes no state change.
